tds_trigger_window_gate: RTL and testbench

Parametrised successor to the single-width trigger gate on the sTGC TDS data-log path. It turns a clk-synchronous trigger level into a programmable delayed acquisition window. It gates per-channel enables for N_CH TDS channels and tags each accepted trigger with an event ID. The event header (ID + channel mask) is queued for readout_control. Unlike the previous gate, it supports configurable delay, retrigger policy, header back-pressure and drop accounting.

---
 rtl/tds_trig_pkg.sv | 24 ++
 rtl/tds_hdr_fifo.sv | 47 ++++
 rtl/tds_trigger_window_gate.sv | 166 ++++++++++++++++
 tb/tb_tds_trigger_window_gate.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/tds_trig_pkg.sv
// Shared types and constants for the TDS trigger window gate and its header FIFO.
package tds_trig_pkg;

  localparam int unsigned DROP_CNT_W   = 16;
  localparam int unsigned EVT_ID_W_DEF = 16;
  localparam int unsigned N_CH_DEF     = 8;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StDelay = 2'd1,
    StOpen  = 2'd2
  } trig_state_e;

  // Header layout for the default configuration; the top packs the same order generically.
  typedef struct packed {
    logic [EVT_ID_W_DEF-1:0] event_id;
    logic [N_CH_DEF-1:0]     ch_mask;
  } hdr_t;

  function automatic int unsigned max_w(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/tds_hdr_fifo.sv
// Synchronous first-word-fall-through FIFO for event headers; push and pop may coincide
// at any fill level, including full.
module tds_hdr_fifo #(
  parameter int unsigned WIDTH = 24,
  parameter int unsigned DEPTH = 4
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_push_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_pop_data,
  output logic             o_full,
  output logic             o_empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0]      r_wr_ptr;
  logic [AW:0]      r_rd_ptr;
  logic             w_do_push;
  logic             w_do_pop;

  assign o_empty   = (r_wr_ptr == r_rd_ptr);
  assign o_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) && (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign w_do_pop  = i_pop & ~o_empty;
  assign w_do_push = i_push & (~o_full | w_do_pop);

  // Head is forced to zero when empty so the header outputs read 0 out of reset.
  assign o_pop_data = o_empty ? '0 : r_mem[r_rd_ptr[AW-1:0]];

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_do_push) r_mem[r_wr_ptr[AW-1:0]] <= i_push_data;
  end

endmodule

// File: rtl/tds_trigger_window_gate.sv
// Turns an accepted trigger rising edge into a delayed, programmable-width acquisition
// window, gates the channel enables and queues an {event ID, channel mask} header.
module tds_trigger_window_gate
  import tds_trig_pkg::*;
#(
  parameter int unsigned N_CH      = 8,
  parameter int unsigned DELAY_W   = 10,
  parameter int unsigned WIDTH_W   = 10,
  parameter int unsigned EVT_ID_W  = 16,
  parameter int unsigned HDR_DEPTH = 4
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_trigger_in,
  input  logic                  i_enable_trigger,
  input  logic [DELAY_W-1:0]    i_trigger_delay,
  input  logic [WIDTH_W-1:0]    i_trigger_width,
  input  logic                  i_retrig_mode,
  input  logic [N_CH-1:0]       i_ch_enable,
  output logic [N_CH-1:0]       o_enable_out,
  output logic                  o_window_open,
  output logic                  o_busy,
  output logic                  o_hdr_valid,
  input  logic                  i_hdr_ready,
  output logic [EVT_ID_W-1:0]   o_hdr_event_id,
  output logic [N_CH-1:0]       o_hdr_ch_mask,
  output logic [DROP_CNT_W-1:0] o_drop_count
);

  localparam int unsigned CNT_W = max_w(DELAY_W, WIDTH_W);
  localparam int unsigned HDR_W = EVT_ID_W + N_CH;

  trig_state_e           r_state;
  trig_state_e           w_state_next;
  logic [CNT_W-1:0]      r_cnt;
  logic [CNT_W-1:0]      w_cnt_next;
  logic [WIDTH_W-1:0]    r_width;
  logic [N_CH-1:0]       r_mask;
  logic [N_CH-1:0]       w_mask_next;
  logic                  r_retrig;
  logic                  r_trig_d;
  logic [EVT_ID_W-1:0]   r_evt_cnt;
  logic [DROP_CNT_W-1:0] r_drop_cnt;
  logic                  r_window_open;
  logic [N_CH-1:0]       r_enable_out;
  logic                  r_busy;

  logic                  w_rise;
  logic                  w_accept;
  logic                  w_drop;
  logic                  w_hdr_full;
  logic                  w_hdr_empty;
  logic                  w_hdr_pop;
  logic                  w_hdr_room;
  logic [HDR_W-1:0]      w_hdr_data;

  assign w_rise      = i_trigger_in & ~r_trig_d & i_enable_trigger;
  assign w_hdr_pop   = ~w_hdr_empty & i_hdr_ready;
  // A full FIFO still takes a header when the consumer pops in the same cycle.
  assign w_hdr_room  = ~w_hdr_full | w_hdr_pop;
  assign w_mask_next = w_accept ? i_ch_enable : r_mask;

  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    w_accept     = 1'b0;
    w_drop       = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (w_rise) begin
          if ((i_trigger_width != '0) && w_hdr_room) begin
            w_accept = 1'b1;
            if (i_trigger_delay != '0) begin
              w_state_next = StDelay;
              w_cnt_next   = CNT_W'(i_trigger_delay);
            end else begin
              w_state_next = StOpen;
              w_cnt_next   = CNT_W'(i_trigger_width);
            end
          end else begin
            w_drop = 1'b1;
          end
        end
      end
      StDelay: begin
        w_drop = w_rise;
        if (r_cnt == CNT_W'(1)) begin
          w_state_next = StOpen;
          w_cnt_next   = CNT_W'(r_width);
        end else begin
          w_cnt_next = r_cnt - 1'b1;
        end
      end
      StOpen: begin
        if (w_rise && r_retrig) begin
          w_cnt_next = CNT_W'(r_width);
        end else begin
          w_drop = w_rise;
          if (r_cnt == CNT_W'(1)) begin
            w_state_next = StIdle;
          end else begin
            w_cnt_next = r_cnt - 1'b1;
          end
        end
      end
      default: begin
        w_state_next = StIdle;
      end
    endcase
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state       <= StIdle;
      r_cnt         <= '0;
      r_width       <= '0;
      r_mask        <= '0;
      r_retrig      <= 1'b0;
      r_trig_d      <= 1'b0;
      r_evt_cnt     <= '0;
      r_drop_cnt    <= '0;
      r_window_open <= 1'b0;
      r_enable_out  <= '0;
      r_busy        <= 1'b0;
    end else begin
      r_state       <= w_state_next;
      r_cnt         <= w_cnt_next;
      r_trig_d      <= i_trigger_in;
      r_mask        <= w_mask_next;
      r_window_open <= (w_state_next == StOpen);
      r_enable_out  <= (w_state_next == StOpen) ? w_mask_next : '0;
      r_busy        <= (w_state_next != StIdle);
      if (w_accept) begin
        r_width   <= i_trigger_width;
        r_retrig  <= i_retrig_mode;
        r_evt_cnt <= r_evt_cnt + 1'b1;
      end
      if (w_drop && (r_drop_cnt != {DROP_CNT_W{1'b1}})) begin
        r_drop_cnt <= r_drop_cnt + 1'b1;
      end
    end
  end

  tds_hdr_fifo #(
    .WIDTH(HDR_W),
    .DEPTH(HDR_DEPTH)
  ) u_hdr_fifo (
    .i_clk       (i_clk),
    .i_reset     (i_reset),
    .i_push      (w_accept),
    .i_push_data ({r_evt_cnt, i_ch_enable}),
    .i_pop       (w_hdr_pop),
    .o_pop_data  (w_hdr_data),
    .o_full      (w_hdr_full),
    .o_empty     (w_hdr_empty)
  );

  assign o_enable_out   = r_enable_out;
  assign o_window_open  = r_window_open;
  assign o_busy         = r_busy;
  assign o_hdr_valid    = ~w_hdr_empty;
  assign o_hdr_event_id = w_hdr_data[HDR_W-1:N_CH];
  assign o_hdr_ch_mask  = w_hdr_data[N_CH-1:0];
  assign o_drop_count   = r_drop_cnt;

endmodule

// File: tb/tb_tds_trigger_window_gate.sv
// Directed bench for tds_trigger_window_gate: table of single-trigger scenarios plus
// hand-written sequences for reset-in-window and header FIFO back-pressure.
module tb_tds_trigger_window_gate;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        trigger_in = 1'b0;
  logic        enable_trigger = 1'b1;
  logic [9:0]  trigger_delay = '0;
  logic [9:0]  trigger_width = '0;
  logic        retrig_mode = 1'b0;
  logic [7:0]  ch_enable = '0;
  logic [7:0]  enable_out;
  logic        window_open;
  logic        busy;
  logic        hdr_valid;
  logic        hdr_ready = 1'b0;
  logic [15:0] hdr_event_id;
  logic [7:0]  hdr_ch_mask;
  logic [15:0] drop_count;

  int n_checks = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  tds_trigger_window_gate dut (
    .i_clk            (clk),
    .i_reset          (reset),
    .i_trigger_in     (trigger_in),
    .i_enable_trigger (enable_trigger),
    .i_trigger_delay  (trigger_delay),
    .i_trigger_width  (trigger_width),
    .i_retrig_mode    (retrig_mode),
    .i_ch_enable      (ch_enable),
    .o_enable_out     (enable_out),
    .o_window_open    (window_open),
    .o_busy           (busy),
    .o_hdr_valid      (hdr_valid),
    .i_hdr_ready      (hdr_ready),
    .o_hdr_event_id   (hdr_event_id),
    .o_hdr_ch_mask    (hdr_ch_mask),
    .o_drop_count     (drop_count)
  );

  typedef struct {
    int         d;
    int         w;
    logic [7:0] msk;
    logic       rt;
    logic       en;
    int         ext;       // edge offset of a second rise after acceptance, -1 = none
    int         exp_first; // sample index of first open cycle, -1 = no window
    int         exp_len;
    logic       exp_hdr;
    int         exp_id;
    int         exp_drop;
  } vec_t;

  vec_t vecs[11];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Sample m (taken after edge k+m) shows cycle k+1+m; edge k is the acceptance edge.
  task automatic fire(input int d, input int w, input logic [7:0] msk, input logic rt,
                      input logic en, input int ext, output int first, output int len,
                      output logic msk_ok, output logic hv0, output logic busy0);
    first = -1;
    len = 0;
    msk_ok = 1'b1;
    hv0 = 1'b0;
    busy0 = 1'b0;
    @(negedge clk);
    trigger_delay = 10'(d);
    trigger_width = 10'(w);
    ch_enable = msk;
    retrig_mode = rt;
    enable_trigger = en;
    trigger_in = 1'b1;
    for (int m = 0; m < 64; m++) begin
      @(negedge clk);
      if (m == 0) begin
        hv0 = hdr_valid;
        busy0 = busy;
      end
      if (window_open) begin
        if (first < 0) first = m;
        len++;
        if (enable_out !== msk) msk_ok = 1'b0;
      end else if (enable_out !== 8'h00) begin
        msk_ok = 1'b0;
      end
      trigger_in = (ext >= 0) && (m == ext - 1);
    end
    enable_trigger = 1'b1;
  endtask

  task automatic pop_one();
    @(negedge clk);
    hdr_ready = 1'b1;
    @(negedge clk);
    hdr_ready = 1'b0;
  endtask

  initial begin
    int first, len;
    logic msk_ok, hv0, busy0;

    //          d  w  msk    rt    en    ext first len hdr   id drop
    vecs[0]  = '{3, 5, 8'hA5, 1'b0, 1'b1, -1, 3,  5, 1'b1, 0, 0};
    vecs[1]  = '{0, 1, 8'h3C, 1'b0, 1'b1, -1, 0,  1, 1'b1, 1, 0};
    vecs[2]  = '{0, 1, 8'hFF, 1'b0, 1'b1, -1, 0,  1, 1'b1, 2, 0};
    vecs[3]  = '{0, 1, 8'h01, 1'b0, 1'b1, -1, 0,  1, 1'b1, 3, 0};
    vecs[4]  = '{0, 4, 8'h5A, 1'b1, 1'b1, 2,  0,  6, 1'b1, 4, 0};
    vecs[5]  = '{0, 4, 8'h5A, 1'b0, 1'b1, 2,  0,  4, 1'b1, 5, 1};
    vecs[6]  = '{2, 0, 8'h77, 1'b0, 1'b1, -1, -1, 0, 1'b0, 0, 2};
    vecs[7]  = '{2, 3, 8'hC3, 1'b1, 1'b1, 4,  2,  5, 1'b1, 6, 2};
    vecs[8]  = '{1, 2, 8'h81, 1'b1, 1'b1, 3,  1,  4, 1'b1, 7, 2};
    vecs[9]  = '{3, 2, 8'h42, 1'b1, 1'b1, 2,  3,  2, 1'b1, 8, 3};
    vecs[10] = '{0, 3, 8'hF0, 1'b0, 1'b0, -1, -1, 0, 1'b0, 0, 3};

    repeat (3) @(negedge clk);
    chk("reset window_open", {31'd0, window_open}, 32'd0);
    chk("reset busy", {31'd0, busy}, 32'd0);
    chk("reset hdr_valid", {31'd0, hdr_valid}, 32'd0);
    chk("reset drop_count", {16'd0, drop_count}, 32'd0);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 11; i++) begin
      fire(vecs[i].d, vecs[i].w, vecs[i].msk, vecs[i].rt, vecs[i].en, vecs[i].ext,
           first, len, msk_ok, hv0, busy0);
      chk($sformatf("v%0d first", i), first, vecs[i].exp_first);
      chk($sformatf("v%0d len", i), len, vecs[i].exp_len);
      chk($sformatf("v%0d enable_out", i), {31'd0, msk_ok}, 32'd1);
      chk($sformatf("v%0d hdr_valid k+1", i), {31'd0, hv0}, {31'd0, vecs[i].exp_hdr});
      chk($sformatf("v%0d busy k+1", i), {31'd0, busy0}, {31'd0, vecs[i].exp_hdr});
      chk($sformatf("v%0d drop_count", i), {16'd0, drop_count}, vecs[i].exp_drop);
      if (vecs[i].exp_hdr) begin
        chk($sformatf("v%0d hdr_id", i), {16'd0, hdr_event_id}, vecs[i].exp_id);
        chk($sformatf("v%0d hdr_mask", i), {24'd0, hdr_ch_mask}, {24'd0, vecs[i].msk});
        pop_one();
      end
      chk($sformatf("v%0d hdr drained", i), {31'd0, hdr_valid}, 32'd0);
    end

    // Reset asserted while the window is open.
    @(negedge clk);
    trigger_delay = 10'd0;
    trigger_width = 10'd8;
    ch_enable = 8'h99;
    retrig_mode = 1'b0;
    trigger_in = 1'b1;
    @(negedge clk);
    trigger_in = 1'b0;
    @(negedge clk);
    chk("pre-reset window_open", {31'd0, window_open}, 32'd1);
    chk("pre-reset hdr_id", {16'd0, hdr_event_id}, 32'd9);
    reset = 1'b1;
    @(negedge clk);
    chk("rst enable_out", {24'd0, enable_out}, 32'd0);
    chk("rst window_open", {31'd0, window_open}, 32'd0);
    chk("rst busy", {31'd0, busy}, 32'd0);
    chk("rst hdr_valid", {31'd0, hdr_valid}, 32'd0);
    chk("rst hdr_id", {16'd0, hdr_event_id}, 32'd0);
    chk("rst hdr_mask", {24'd0, hdr_ch_mask}, 32'd0);
    chk("rst drop_count", {16'd0, drop_count}, 32'd0);
    reset = 1'b0;
    @(negedge clk);

    // Back-pressure: four headers fill the FIFO, the fifth trigger is dropped.
    for (int i = 0; i < 5; i++) begin
      fire(0, 1, 8'(8'h10 + i), 1'b0, 1'b1, -1, first, len, msk_ok, hv0, busy0);
      chk($sformatf("full t%0d len", i), len, (i < 4) ? 1 : 0);
    end
    chk("full drop_count", {16'd0, drop_count}, 32'd1);
    chk("full head id", {16'd0, hdr_event_id}, 32'd0);

    // Pop and trigger in the same cycle while full: accepted as ID 4.
    @(negedge clk);
    trigger_in = 1'b1;
    hdr_ready = 1'b1;
    ch_enable = 8'h14;
    @(negedge clk);
    trigger_in = 1'b0;
    hdr_ready = 1'b0;
    chk("full+pop window_open", {31'd0, window_open}, 32'd1);
    chk("full+pop drop_count", {16'd0, drop_count}, 32'd1);
    for (int i = 1; i <= 4; i++) begin
      chk($sformatf("drain %0d valid", i), {31'd0, hdr_valid}, 32'd1);
      chk($sformatf("drain %0d id", i), {16'd0, hdr_event_id}, i);
      chk($sformatf("drain %0d mask", i), {24'd0, hdr_ch_mask}, 32'h10 + i);
      pop_one();
    end
    chk("drain empty", {31'd0, hdr_valid}, 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
